// File: rtl/gb_pkg.sv
// Shared definitions for the global-buffer control blocks:
// the FSM state encoding and the batch-count width helper.
package gb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to hold a count from 0 to batch_size inclusive.
  function automatic int cnt_width(input int batch_size);
    return $clog2(batch_size + 1);
  endfunction

endpackage

// File: rtl/execute2gb_fifo.sv
// Small synchronous result FIFO with a registered head word and registered
// full/empty flags. Push and pop may occur together, including when full.
module execute2gb_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [AW:0]           count, count_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  do_push, do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  // Next occupancy and next head word.
  always_comb begin
    count_nxt = count;
    head_nxt  = head;
    if (do_push && !do_pop)      count_nxt = count + (AW+1)'(1);
    else if (!do_push && do_pop) count_nxt = count - (AW+1)'(1);
    if (do_pop) begin
      if (count == (AW+1)'(1)) begin
        if (do_push) head_nxt = din;
      end else begin
        head_nxt = mem[rd_ptr + AW'(1)];
      end
    end else if (do_push && count == '0) begin
      head_nxt = din;
    end
  end

  // Storage array; contents need no reset since the pointers gate them.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy, flags and head register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
      head  <= head_nxt;
    end
  end

endmodule

// File: rtl/execute2gb_cntl.sv
// Execute-to-global-buffer writeback controller. Buffers execute results in a
// skid FIFO and writes them to sequential addresses from a programmed base.
// Optional macro EXECUTE2GB_RELU_EN clamps negative write data to zero.
module execute2gb_cntl
  import gb_pkg::*;
#(
  parameter int BATCH_SIZE = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [$clog2(BATCH_SIZE+1)-1:0]  num_rows,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  input  logic                             ex_valid,
  output logic                             ex_ready,
  input  logic [DATA_WIDTH-1:0]            ex_data,
  input  logic                             ex_last,
  output logic                             gb_wr_en,
  output logic [ADDR_WIDTH-1:0]            gb_wr_addr,
  output logic [DATA_WIDTH-1:0]            gb_wr_data,
  input  logic                             gb_wr_ready
);
  localparam int CW = cnt_width(BATCH_SIZE);

  state_t                state, state_nxt;
  logic [CW-1:0]         rows_q, rows_in, acc_cnt, acc_nxt, wr_cnt, wr_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  fifo_full, fifo_empty, accept, wr_fire, go;
  logic [DATA_WIDTH-1:0] head;

  assign rows_in  = (num_rows > CW'(BATCH_SIZE)) ? CW'(BATCH_SIZE) : num_rows;
  assign go       = (state == IDLE) && start;
  assign ex_ready = (state == RUN) && !fifo_full && (acc_cnt < rows_q);
  assign accept   = ex_valid && ex_ready;
  assign gb_wr_en = !fifo_empty && ((state == RUN) || (state == DRAIN));
  assign wr_fire  = gb_wr_en && gb_wr_ready;
  assign acc_nxt  = acc_cnt + CW'(accept);
  assign wr_nxt   = wr_cnt + CW'(wr_fire);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Address advances only on a completed write, so it holds through stalls.
  assign gb_wr_addr = base_q + ADDR_WIDTH'(wr_cnt);

`ifdef EXECUTE2GB_RELU_EN
  assign gb_wr_data = head[DATA_WIDTH-1] ? '0 : head;
`else
  assign gb_wr_data = head;
`endif

  execute2gb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (1'b0),
    .push  (accept),
    .pop   (wr_fire),
    .din   (ex_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Transitions look at post-handshake counts so done lands one cycle after
  // the final write.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (rows_in == '0) ? DONE : RUN;
      RUN:     if (acc_nxt == rows_q) state_nxt = DRAIN;
      DRAIN:   if (wr_nxt == rows_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, batch parameters, counters and sticky ex_last error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rows_q  <= '0;
      base_q  <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go) begin
        rows_q  <= rows_in;
        base_q  <= base_addr;
        acc_cnt <= '0;
        wr_cnt  <= '0;
        err     <= 1'b0;
      end else begin
        acc_cnt <= acc_nxt;
        wr_cnt  <= wr_nxt;
        // ex_last must coincide exactly with the final counted result.
        if (accept && (ex_last != ((acc_cnt + CW'(1)) == rows_q))) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_execute2gb_cntl.sv
// Scoreboard bench for execute2gb_cntl: batches are modelled as lists of
// (address, data) writes plus an expected error flag; a monitor checks them.
module tb_execute2gb_cntl;
  localparam int BS = 128;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = $clog2(BS+1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [NW-1:0] num_rows = '0;
  logic          ex_valid = 1'b0;
  logic [DW-1:0] ex_data = '0;
  logic          ex_last = 1'b0;
  logic          gb_wr_ready = 1'b1;
  logic          busy, done, err, ex_ready, gb_wr_en;
  logic [AW-1:0] gb_wr_addr;
  logic [DW-1:0] gb_wr_data;

  execute2gb_cntl #(.BATCH_SIZE(BS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .err(err), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_data(ex_data), .ex_last(ex_last), .gb_wr_en(gb_wr_en), .gb_wr_addr(gb_wr_addr),
    .gb_wr_data(gb_wr_data), .gb_wr_ready(gb_wr_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int n; bit err; int start_cyc; bit tput; } bat_t;

  wr_t  wq[$];
  bat_t bq[$];
  int   tests = 0, fails = 0;
  bit   sb_on = 1'b1;
  int   last_wr_cyc = -100;
  int   rdy_mode = 1;  // 0 random, 1 held high, 2 held low

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
`ifdef EXECUTE2GB_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ex_ready"}, ex_ready, 0);
    check({tag, "_wr_en"}, gb_wr_en, 0);
    check({tag, "_wr_addr"}, gb_wr_addr, 0);
    check({tag, "_wr_data"}, gb_wr_data, 0);
  endtask

  // Global buffer arbitration model.
  initial forever begin
    @(posedge clock);
    #1;
    case (rdy_mode)
      0:       gb_wr_ready = ($urandom_range(0, 3) != 0);
      1:       gb_wr_ready = 1'b1;
      default: gb_wr_ready = 1'b0;
    endcase
  end

  // Monitor: checks each write against the scoreboard, stall stability, done.
  initial begin
    bit            pstall;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    wr_t           e;
    bat_t          b;
    pstall = 1'b0;
    forever begin
      @(negedge clock);
      if (reset || !sb_on) begin
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          check("stall_hold_en", gb_wr_en, 1);
          check("stall_hold_addr", gb_wr_addr, pa);
          check("stall_hold_data", gb_wr_data, pd);
        end
        if (gb_wr_en && gb_wr_ready) begin
          if (wq.size() == 0) fail_now("unexpected_write");
          else begin
            e = wq.pop_front();
            check("wr_addr", gb_wr_addr, e.addr);
            check("wr_data", gb_wr_data, e.data);
          end
          last_wr_cyc = cyc;
        end
        if (done) begin
          if (bq.size() == 0) fail_now("unexpected_done");
          else begin
            b = bq.pop_front();
            check("err_at_done", err, b.err);
            check("busy_at_done", busy, 1);
            check("writes_left_at_done", wq.size(), 0);
            if (b.n > 0) check("done_after_last_write", cyc - last_wr_cyc, 1);
            else         check("done_zero_rows", cyc - b.start_cyc, 1);
            if (b.tput)  check("throughput", cyc - b.start_cyc, b.n + 2);
          end
        end
        pstall = gb_wr_en && !gb_wr_ready;
        pa = gb_wr_addr;
        pd = gb_wr_data;
      end
    end
  end

  // Present one result and hold it until accepted (bounded).
  task automatic send_one(input logic [DW-1:0] d, input bit last, output bit ok);
    bit acc;
    int k;
    ex_valid = 1'b1;
    ex_data  = d;
    ex_last  = last;
    ok = 1'b0;
    for (k = 0; k < 500; k++) begin
      @(negedge clock);
      acc = ex_ready;
      @(posedge clock);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    ex_valid = 1'b0;
    ex_last  = 1'b0;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input int nreq);
    @(posedge clock);
    #1;
    start     = 1'b1;
    base_addr = base;
    num_rows  = NW'(nreq);
  endtask

  task automatic run_batch(input logic [AW-1:0] base, input int nreq, input int lastpos,
                           input bit gaps, input bit tput, input logic [DW-1:0] d[$]);
    int   n, k;
    bit   ok;
    bat_t b;
    n = (nreq > BS) ? BS : nreq;
    for (int i = 0; i < n; i++) wq.push_back('{addr: base + AW'(i), data: relu(d[i])});
    pulse_start(base, nreq);
    b.n = n; b.err = (n > 0) && (lastpos != n - 1); b.start_cyc = cyc; b.tput = tput;
    bq.push_back(b);
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clock);
      if (gaps) #1;
      send_one(d[i], (i == lastpos), ok);
      if (!ok) break;
    end
    k = 0;
    while (bq.size() != 0 && k < 2000) begin
      @(posedge clock);
      k++;
    end
    if (bq.size() != 0) fail_now("batch_done_timeout");
    wq.delete();
    bq.delete();
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [DW-1:0] dq[$];
    bit            ok;
    int            n, lp;

    // Reset state.
    repeat (2) @(negedge clock);
    check_reset_vals("reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("post_reset");

    // Basic batch, back-to-back at full rate.
    rdy_mode = 1;
    dq.delete();
    for (int i = 1; i <= 4; i++) dq.push_back(DW'(i));
    run_batch(32'h100, 4, 3, 1'b0, 1'b1, dq);

    // Backpressure: buffer stalled for 6 cycles, FIFO fills to 4.
    dq.delete();
    for (int i = 0; i < 8; i++) dq.push_back($urandom);
    rdy_mode = 2;
    fork
      run_batch(32'h2000, 8, 7, 1'b0, 1'b0, dq);
      begin
        @(posedge start);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("bp_ex_ready_low_when_full", ex_ready, 0);
        check("bp_wr_en_during_stall", gb_wr_en, 1);
        repeat (2) @(posedge clock);
        rdy_mode = 1;
      end
    join

    // Address wrap-around.
    dq.delete();
    for (int i = 0; i < 4; i++) dq.push_back($urandom);
    run_batch(32'hFFFF_FFFE, 4, 3, 1'b0, 1'b0, dq);

    // Zero-row batch.
    dq.delete();
    run_batch(32'h40, 0, -1, 1'b0, 1'b0, dq);

    // Early ex_last, then a clean batch clears err.
    dq.delete();
    for (int i = 0; i < 3; i++) dq.push_back($urandom);
    run_batch(32'h300, 3, 1, 1'b0, 1'b0, dq);
    check("err_sticky_after_batch", err, 1);
    run_batch(32'h400, 3, 2, 1'b0, 1'b0, dq);
    check("err_cleared_by_start", err, 0);

    // Reset in the middle of a batch.
    sb_on = 1'b0;
    pulse_start(32'h500, 5);
    @(posedge clock);
    #1;
    start = 1'b0;
    send_one(32'h11, 1'b0, ok);
    send_one(32'h22, 1'b0, ok);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    wq.delete();
    bq.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sb_on = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    dq.delete();
    dq.push_back(32'hA5); dq.push_back(32'h5A);
    run_batch(32'h600, 2, 1, 1'b0, 1'b0, dq);

    // Sign handling of write data.
    dq.delete();
    dq.push_back(-32'sd5); dq.push_back(32'd7); dq.push_back(32'h8000_0000);
    run_batch(32'h700, 3, 2, 1'b0, 1'b1, dq);

    // num_rows above BATCH_SIZE is clamped.
    rdy_mode = 0;
    dq.delete();
    for (int i = 0; i < BS; i++) dq.push_back($urandom);
    run_batch(32'h1000, 200, BS - 1, 1'b0, 1'b0, dq);

    // Randomized batches with random stalls, gaps and occasional ex_last errors.
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 12);
      lp = n - 1;
      if ($urandom_range(0, 3) == 0) lp = $urandom_range(0, n) - 1;
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back($urandom);
      run_batch($urandom, n, lp, 1'b1, 1'b0, dq);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/execute2gb_cntl.md
# execute2gb_cntl

Writeback controller from the execute unit back into the global buffer, the return path to the buffer-to-execute control. Accepts a valid/ready result stream from the execute unit, buffers it in a small FIFO, and issues sequential writes into the global buffer activation region starting at a programmed base address. Signals batch completion once every expected result has been committed.

## Interface
Parameters:
- BATCH_SIZE, 128, maximum results per batch
- ADDR_WIDTH, 32, global buffer address width
- DATA_WIDTH, 32, result word width, two's complement
- FIFO_DEPTH, 4, result skid FIFO entries; power of two, at least 2

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a batch; ignored while busy
- base_addr  in  ADDR_WIDTH  first write address, captured on start
- num_rows  in  $clog2(BATCH_SIZE+1)  results in this batch, captured on start; values above BATCH_SIZE are clamped to BATCH_SIZE
- busy  out  1  high from the cycle after start until the done cycle, inclusive
- done  out  1  one-cycle pulse after the last write handshake
- err  out  1  sticky; set on ex_last mismatch; cleared by the next accepted start
- ex_valid  in  1  execute result valid
- ex_ready  out  1  controller can accept a result
- ex_data  in  DATA_WIDTH  result word
- ex_last  in  1  marks the final result of the batch
- gb_wr_en  out  1  write request
- gb_wr_addr  out  ADDR_WIDTH  write address
- gb_wr_data  out  DATA_WIDTH  write data
- gb_wr_ready  in  1  global buffer accepts the write; low means arbitration stall

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE to RUN on start. If num_rows==0, IDLE goes to DONE instead.
- RUN to DRAIN once acc_cnt==num_rows.
- DRAIN to DONE once wr_cnt==num_rows.
- DONE to IDLE unconditionally after one cycle.
- acc_cnt increments on each ex_valid&&ex_ready.
- ex_ready = (state==RUN) && !fifo_full && (acc_cnt<num_rows).
- wr_cnt increments on each gb_wr_en&&gb_wr_ready.
- gb_wr_en = !fifo_empty, in RUN or DRAIN.
- gb_wr_addr = base_addr + wr_cnt, modulo 2^ADDR_WIDTH. Wrap-around is legal and is not an error.
- gb_wr_data = FIFO head word.
- Accepting and writing in the same cycle is allowed. The FIFO count is unchanged in that case, including when the FIFO is full.
- ex_last mismatch sets err:
  - ex_last accepted with acc_cnt+1 != num_rows, or
  - final result accepted without ex_last.
- On a mismatch the batch still completes on the num_rows count.
- ex_valid while not in RUN is ignored; nothing is accepted.
- gb_wr_en, gb_wr_addr and gb_wr_data hold stable while gb_wr_ready is low.

## Timing
- Reset values: busy=0, done=0, err=0, ex_ready=0, gb_wr_en=0, gb_wr_addr=0, gb_wr_data=0. FSM is IDLE, counters are 0, FIFO is empty.
- start at cycle S: busy=1 and ex_ready may be 1 at S+1.
- A result accepted at cycle N appears on gb_wr_* no earlier than N+1. All FIFO outputs are registered.
- Last write handshake at cycle W: done=1 and busy=1 at W+1; busy=0 at W+2.
- num_rows==0 with start at S: done=1 at S+1.
- Reset asserted mid-batch:
  - takes effect immediately and asynchronously;
  - flushes the FIFO and drops any in-flight write;
  - no done pulse follows.
- With gb_wr_ready held high and ex_valid continuous, throughput is one result per cycle.

## Configuration
- EXECUTE2GB_RELU_EN defined: gb_wr_data is forced to 0 when the FIFO head word is negative (MSB=1). The clamp is combinational on the FIFO output and adds no latency.
- EXECUTE2GB_RELU_EN undefined: data passes through unchanged.

## Structure
- Shared package gb_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - the count-width helper function, clog2 of BATCH_SIZE+1.
- One sub-module, execute2gb_fifo: a synchronous FIFO parameterized on DATA_WIDTH and FIFO_DEPTH.
  - Outputs: full, empty, registered head.
  - Supports simultaneous push and pop, including when full.
  - Has a synchronous flush input, unused by this block, plus the shared asynchronous reset.
- The FSM, counters, address generation and ReLU stay in execute2gb_cntl.

## Test plan
- Basic batch: base_addr=0x100, num_rows=4, data 1..4 back-to-back, gb_wr_ready=1.
  - Expect writes to 0x100..0x103 with data 1..4.
  - Expect done exactly one cycle after the 4th write; err=0.
- Backpressure: num_rows=8, gb_wr_ready low for 6 cycles.
  - Expect ex_ready to drop once 4 entries are buffered.
  - Expect gb_wr_* to hold stable through the stall.
  - Expect all 8 writes in order, with no loss or duplication.
- Address wrap: ADDR_WIDTH=8, base_addr=0xFE, num_rows=4.
  - Expect addresses 0xFE, 0xFF, 0x00, 0x01; err=0.
- Boundary cases:
  - num_rows=0: done at S+1, no gb_wr_en.
  - ex_last on the 2nd of 3 results: err=1, 3 writes still issued, done asserted.
  - Next accepted start clears err.
- Reset mid-batch: assert reset after 2 of 5 results are accepted.
  - Expect all outputs at reset values, no done.
  - A new batch with num_rows=2 completes normally.
- ReLU build, EXECUTE2GB_RELU_EN defined: data -5, 7, 0x80000000.
  - Expect written data 0, 7, 0.
  - Without the macro, expect -5, 7, 0x80000000.
